// File: rtl/systolic_array_nxn_pkg.sv
// Shared definitions for the N x N systolic matrix multiplier: FSM states,
// default parameter values and a width helper.
package systolic_array_nxn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_N      = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_K_MAX  = 16;
  localparam int DEF_SIGNED = 0;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/systolic_array_nxn_mac_pe.sv
// One processing element: forwards A right and B down through registers and
// accumulates a*b every cycle, clearing on clr.
module mac_pe
  import systolic_array_nxn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = 2*DEF_DATA_W+4,
  parameter int SIGNED = DEF_SIGNED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
);

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  prod_ext;

  // The size cast extends according to the product's signedness.
  if (SIGNED != 0) begin : g_signed
    logic signed [2*DATA_W-1:0] prod;
    assign prod     = $signed(a_in) * $signed(b_in);
    assign prod_ext = ACC_W'(prod);
  end else begin : g_unsigned
    logic [2*DATA_W-1:0] prod;
    assign prod     = a_in * b_in;
    assign prod_ext = ACC_W'(prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_in;
      b_q   <= b_in;
      acc_q <= clr ? '0 : acc_q + prod_ext;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_array_nxn.sv
// Output-stationary N x N systolic array computing C = A x B over k_len
// beats, with input skew lines and a LOAD/DRAIN job controller.
module systolic_array_nxn
  import systolic_array_nxn_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = 2*DATA_W+4,
  parameter int K_MAX  = DEF_K_MAX,
  parameter int SIGNED = DEF_SIGNED
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [clog2(K_MAX+1)-1:0]    k_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N*DATA_W-1:0]          a_col,
  input  logic [N*DATA_W-1:0]          b_row,
  output logic                         busy,
  output logic                         done,
  output logic [N*N*ACC_W-1:0]         result
);

  localparam int KW = clog2(K_MAX+1);
  localparam int CW = clog2(2*N);

  state_e        state_q;
  logic [KW-1:0] klen_q;
  logic [KW-1:0] beats_q;
  logic [CW-1:0] drain_q;
  logic          in_ready_q;
  logic          busy_q;
  logic          done_q;

  logic start_ok;
  logic fire;

  assign start_ok = start && (state_q == IDLE || state_q == DONE) &&
                    (k_len != '0) && (k_len <= KW'(K_MAX));
  assign fire     = in_valid && in_ready_q;

  // DRAIN lasts 2N edges: enough for the last beat to cross the skewed array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      klen_q     <= '0;
      beats_q    <= '0;
      drain_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            state_q    <= LOAD;
            klen_q     <= k_len;
            beats_q    <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        LOAD: begin
          if (fire) begin
            beats_q <= beats_q + KW'(1);
            if (beats_q + KW'(1) == klen_q) begin
              state_q    <= DRAIN;
              drain_q    <= '0;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          drain_q <= drain_q + CW'(1);
          if (drain_q == CW'(2*N-1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Bubbles and idle cycles feed zeros so the accumulators are untouched.
  logic [N*DATA_W-1:0] a_gated;
  logic [N*DATA_W-1:0] b_gated;
  logic [N*DATA_W-1:0] a_skewed;
  logic [N*DATA_W-1:0] b_skewed;

  assign a_gated = fire ? a_col : '0;
  assign b_gated = fire ? b_row : '0;

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_skewed[0 +: DATA_W] = a_gated[0 +: DATA_W];
      assign b_skewed[0 +: DATA_W] = b_gated[0 +: DATA_W];
    end else begin : g_dly
      logic [DATA_W-1:0] a_dly_q [0:i-1];
      logic [DATA_W-1:0] b_dly_q [0:i-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < i; s++) begin
            a_dly_q[s] <= '0;
            b_dly_q[s] <= '0;
          end
        end else begin
          a_dly_q[0] <= a_gated[i*DATA_W +: DATA_W];
          b_dly_q[0] <= b_gated[i*DATA_W +: DATA_W];
          for (int s = 1; s < i; s++) begin
            a_dly_q[s] <= a_dly_q[s-1];
            b_dly_q[s] <= b_dly_q[s-1];
          end
        end
      end

      assign a_skewed[i*DATA_W +: DATA_W] = a_dly_q[i-1];
      assign b_skewed[i*DATA_W +: DATA_W] = b_dly_q[i-1];
    end
  end

  logic [DATA_W-1:0] a_h [N][N+1];
  logic [DATA_W-1:0] b_v [N+1][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    assign a_h[i][0] = a_skewed[i*DATA_W +: DATA_W];
    assign b_v[0][i] = b_skewed[i*DATA_W +: DATA_W];
    for (genvar j = 0; j < N; j++) begin : g_col
      mac_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .a_in  (a_h[i][j]),
        .b_in  (b_v[i][j]),
        .a_out (a_h[i][j+1]),
        .b_out (b_v[i+1][j]),
        .acc   (result[(i*N+j)*ACC_W +: ACC_W])
      );
    end
  end

endmodule
